// File: rtl/rv32i_pkg.sv
// Shared rv32i core types and constants; this slice holds the instruction-cache items.
package rv32i_pkg;

  localparam int unsigned DPW = 32;

  localparam logic [DPW-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2
  } icache_state_e;

  function automatic int unsigned ic_index_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned ic_offset_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Word-aligned address bits left over once index and offset are taken.
  function automatic int unsigned ic_tag_bits(input int unsigned num_lines,
                                              input int unsigned words_per_line);
    return DPW - 2 - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/i_cache_refill_fsm.sv
// Miss/refill sequencer: request handshake, refill word counter and sticky flush tracking.
module i_cache_refill_fsm
  import rv32i_pkg::*;
#(
  parameter  int unsigned WordsPerLine = 4,
  localparam int unsigned OffsetBits   = ic_offset_bits(WordsPerLine)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss,
  input  logic                  flush,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  output icache_state_e         state,
  output logic                  mem_req_valid,
  output logic                  word_we_c,
  output logic [OffsetBits-1:0] word_idx,
  output logic                  line_we_c
);

  localparam logic [OffsetBits-1:0] LastWord = OffsetBits'(WordsPerLine - 1);

  icache_state_e         state_q, state_d;
  logic [OffsetBits-1:0] cnt_q, cnt_d;
  logic                  flushed_q, flushed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    word_we_c = 1'b0;
    line_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) state_d = REQ;
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (mem_rsp_valid) begin
          word_we_c = 1'b1;
          cnt_d     = cnt_q + OffsetBits'(1);
          if (cnt_q == LastWord) begin
            state_d   = IDLE;
            // A flush seen at any point during this refill leaves the line invalid.
            line_we_c = ~flushed_q & ~flush;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush && (state_q != IDLE)) flushed_d = 1'b1;
    if (state_d == IDLE) flushed_d = 1'b0;
  end

  assign state         = state_q;
  assign mem_req_valid = (state_q == REQ);
  assign word_idx      = cnt_q;

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped read-only instruction cache for the fetch stage; same-cycle hit, line refill on miss.
module i_cache_dm
  import rv32i_pkg::*;
#(
  parameter int unsigned NumLines     = 16,
  parameter int unsigned WordsPerLine = 4,
  parameter int unsigned MissCntWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DPW-1:0]          PCF,
  input  logic                    req_valid,
  input  logic                    flush,
  output logic [DPW-1:0]          instr,
  output logic                    instr_valid,
  output logic                    stall,
  output logic                    mem_req_valid,
  output logic [DPW-1:0]          mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DPW-1:0]          mem_rsp_data,
  output logic [MissCntWidth-1:0] miss_cnt
);

  localparam int unsigned IndexBits  = ic_index_bits(NumLines);
  localparam int unsigned OffsetBits = ic_offset_bits(WordsPerLine);
  localparam int unsigned TagBits    = ic_tag_bits(NumLines, WordsPerLine);
  localparam int unsigned LineBits   = TagBits + IndexBits;
  localparam int unsigned WordSlots  = NumLines * WordsPerLine;

  logic [OffsetBits-1:0] pc_off;
  logic [IndexBits-1:0]  pc_idx;
  logic [TagBits-1:0]    pc_tag;
  logic                  unused_pc_bits;

  assign pc_off         = PCF[OffsetBits+1:2];
  assign pc_idx         = PCF[OffsetBits+IndexBits+1:OffsetBits+2];
  assign pc_tag         = PCF[DPW-1:DPW-TagBits];
  assign unused_pc_bits = ^PCF[1:0];

  logic [DPW-1:0]          data_q [WordSlots];
  logic [TagBits-1:0]      tag_q  [NumLines];
  logic [NumLines-1:0]     valid_q;
  logic [LineBits-1:0]     miss_line_q;
  logic [MissCntWidth-1:0] miss_cnt_q;

  icache_state_e         state;
  logic                  hit;
  logic                  miss;
  logic                  word_we;
  logic                  line_we;
  logic [OffsetBits-1:0] word_idx;
  logic [IndexBits-1:0]  fill_idx;
  logic [TagBits-1:0]    fill_tag;

  assign hit = req_valid & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag) & (state == IDLE);
  assign miss = (state == IDLE) & req_valid & ~hit & ~flush;

  assign fill_idx = miss_line_q[IndexBits-1:0];
  assign fill_tag = miss_line_q[LineBits-1:IndexBits];

  i_cache_refill_fsm #(
    .WordsPerLine (WordsPerLine)
  ) u_refill_fsm (
    .clk           (clk),
    .rst           (rst),
    .miss          (miss),
    .flush         (flush),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .state         (state),
    .mem_req_valid (mem_req_valid),
    .word_we_c     (word_we),
    .word_idx      (word_idx),
    .line_we_c     (line_we)
  );

  // Storage arrays and the latched miss line carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (miss) miss_line_q <= PCF[DPW-1:OffsetBits+2];
    if (word_we) data_q[{fill_idx, word_idx}] <= mem_rsp_data;
    if (line_we) tag_q[fill_idx] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else if (miss && !(&miss_cnt_q)) begin
      miss_cnt_q <= miss_cnt_q + MissCntWidth'(1);
    end
  end

  assign instr        = hit ? data_q[{pc_idx, pc_off}] : NOP_INSTR;
  assign instr_valid  = hit;
  assign stall        = (req_valid & ~hit) | (state != IDLE);
  assign mem_req_addr = {miss_line_q, (OffsetBits + 2)'(0)};
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_i_cache_dm.sv
// Directed bench for i_cache_dm: stimulus pushes expected fetches/requests, a monitor checks them.
module tb_i_cache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = 32'h0;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic [15:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_instr [$];
  logic [31:0] exp_addr  [$];
  logic [31:0] wd [4];

  localparam logic [31:0] NOP = 32'h0000_0013;

  i_cache_dm dut (
    .clk           (clk),
    .rst           (rst),
    .PCF           (PCF),
    .req_valid     (req_valid),
    .flush         (flush),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every delivered instruction and accepted refill request is scored against the queues.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (exp_instr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got 0x%08h expected none at %0t", instr, $time);
      end else begin
        chk("instr", instr, exp_instr.pop_front());
      end
    end
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (exp_addr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got 0x%08h expected none at %0t", mem_req_addr, $time);
      end else begin
        chk("req_addr", mem_req_addr, exp_addr.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss on pc, handshake after nwait stalled cycles, deliver wd[0..3]; flush on word flush_at.
  task automatic miss_refill(input logic [31:0] pc, input logic [31:0] base,
                             input int nwait, input int flush_at);
    req_valid = 1'b1;
    PCF = pc;
    exp_addr.push_back(base);
    @(negedge clk);
    chk1("miss_stall", stall, 1'b1);
    chk("miss_nop", instr, NOP);
    chk1("miss_ivalid", instr_valid, 1'b0);
    step();
    for (int i = 0; i < nwait; i++) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk1("bp_req_valid", mem_req_valid, 1'b1);
      chk("bp_req_addr", mem_req_addr, base);
      chk1("bp_stall", stall, 1'b1);
      step();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk1("req_valid", mem_req_valid, 1'b1);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = wd[i];
      flush = (i == flush_at);
      @(negedge clk);
      chk1("refill_stall", stall, 1'b1);
      step();
    end
    mem_rsp_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic expect_hit(input logic [31:0] pc, input logic [31:0] exp);
    req_valid = 1'b1;
    PCF = pc;
    exp_instr.push_back(exp);
    @(negedge clk);
    chk1("hit_stall", stall, 1'b0);
    step();
  endtask

  task automatic load_line(input logic [31:0] a, b, c, d);
    wd[0] = a; wd[1] = b; wd[2] = c; wd[3] = d;
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    step();

    // Cold miss on line 0
    load_line(32'h0050_0113, 32'h00C0_0193, NOP, NOP);
    miss_refill(32'h0, 32'h0, 0, -1);
    expect_hit(32'h0, 32'h0050_0113);
    expect_hit(32'h4, 32'h00C0_0193);
    expect_hit(32'h8, NOP);
    chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);

    // Conflict: same index, different tag, then back
    load_line(32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004);
    miss_refill(32'h100, 32'h100, 0, -1);
    expect_hit(32'h100, 32'hA000_0001);
    expect_hit(32'h10C, 32'hA000_0004);
    load_line(32'h0050_0113, 32'h00C0_0193, NOP, NOP);
    miss_refill(32'h0, 32'h0, 0, -1);
    expect_hit(32'h0, 32'h0050_0113);
    chk("conflict_miss_cnt", 32'(miss_cnt), 32'd3);

    // Back-pressure on the request channel
    load_line(32'hB000_0010, 32'hB000_0011, 32'hB000_0012, 32'hB000_0013);
    miss_refill(32'h24, 32'h20, 5, -1);
    expect_hit(32'h24, 32'hB000_0011);
    expect_hit(32'h2C, 32'hB000_0013);
    chk("bp_miss_cnt", 32'(miss_cnt), 32'd4);

    // Flush after two refill words: line stays invalid and misses again
    load_line(32'hC000_0020, 32'hC000_0021, 32'hC000_0022, 32'hC000_0023);
    miss_refill(32'h30, 32'h30, 0, 2);
    chk("flush_miss_cnt1", 32'(miss_cnt), 32'd5);
    miss_refill(32'h30, 32'h30, 0, -1);
    expect_hit(32'h38, 32'hC000_0022);
    chk("flush_miss_cnt2", 32'(miss_cnt), 32'd6);

    // Flush in IDLE suppresses the miss start
    req_valid = 1'b1;
    PCF = 32'h50;
    flush = 1'b1;
    @(negedge clk);
    chk1("idle_flush_stall", stall, 1'b1);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk1("idle_flush_no_req", mem_req_valid, 1'b0);
    chk("idle_flush_miss_cnt", 32'(miss_cnt), 32'd6);
    step();

    // Reset after one refill word; remaining words are strays
    req_valid = 1'b1;
    PCF = 32'h40;
    exp_addr.push_back(32'h40);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hD000_0000;
    step();
    rst = 1'b1;
    req_valid = 1'b0;
    mem_rsp_data = 32'hD000_0001;
    step();
    rst = 1'b0;
    mem_rsp_data = 32'hD000_0002;
    @(negedge clk);
    chk1("rstmid_req_valid", mem_req_valid, 1'b0);
    chk1("rstmid_stall", stall, 1'b0);
    chk("rstmid_miss_cnt", 32'(miss_cnt), 32'd0);
    step();
    mem_rsp_data = 32'hD000_0003;
    @(negedge clk);
    chk1("rstmid_stray_stall", stall, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    load_line(32'h0050_0113, 32'h00C0_0193, NOP, NOP);
    miss_refill(32'h0, 32'h0, 0, -1);
    expect_hit(32'h4, 32'h00C0_0193);
    chk("rstmid_miss_cnt2", 32'(miss_cnt), 32'd1);

    // Idle: no request with an uncached PCF
    req_valid = 1'b0;
    PCF = 32'h80;
    @(negedge clk);
    chk1("idle_stall", stall, 1'b0);
    chk1("idle_ivalid", instr_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("idle_no_req", mem_req_valid, 1'b0);
    chk("idle_miss_cnt", 32'(miss_cnt), 32'd1);
    step();

    chk("pending_instr", 32'(exp_instr.size()), 32'd0);
    chk("pending_addr", 32'(exp_addr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
